golomb_mark_counter: RTL and testbench

- One mark of the hardware Golomb-ruler search; the ruler assembly instantiates one per mark index 1..NUMPOSITIONS.
- When the assembly's enabled index equals POSITION, the mark searches upward for the next position whose differences to all lower marks are unused.
- It then reports the next index to enable (advance, repeat or backtrack) and the start value for the successor.
- The LEAF variant is the last mark: instead of advancing it flags a complete ruler.

---
 rtl/golomb_mark_counter_pkg.sv | 35 +++
 rtl/golomb_mark_counter_if.sv | 37 +++
 rtl/golomb_diff_hash.sv | 35 +++
 rtl/golomb_mark_head.sv | 14 +
 rtl/golomb_mark_counter.sv | 121 ++++++++++++
 tb/tb_golomb_mark_counter.sv | 289 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/golomb_mark_counter_pkg.sv
// Shared definitions for the Golomb-ruler mark counters: default widths,
// the mark search state type and a helper that unpacks one mark value
// from the flattened marks bus.
package golomb_mark_counter_pkg;

    localparam int DEF_VALW         = 9;
    localparam int DEF_NUMW         = 4;
    localparam int DEF_MAXVALUE     = 100;
    localparam int DEF_NUMPOSITIONS = 5;

    // Upper bound on marks carried by marks_in (index width 4 -> 16 slots).
    localparam int MARK_SLOTS  = 16;
    localparam int MARKS_MAX_W = MARK_SLOTS * DEF_VALW;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } mark_state_e;

    // marks_in holds {m[0], ..., m[npos]} with m[0] in the MSBs, so m[idx]
    // lives in slot (npos - idx) counted from the LSB end.
    function automatic logic [DEF_VALW-1:0] mark_at(
        input logic [MARKS_MAX_W-1:0] flat,
        input int                     idx,
        input int                     npos
    );
        logic [DEF_VALW-1:0] r;
        r = '0;
        for (int s = 0; s < MARK_SLOTS; s++) begin
            if (s == npos - idx) r = flat[s*DEF_VALW +: DEF_VALW];
        end
        return r;
    endfunction

endpackage

// File: rtl/golomb_mark_counter_if.sv
// Ruler-assembly bus seen by one mark: enable/ready handshake, search
// bounds, shared distance set and the mark's reported results.
interface golomb_mark_counter_if
    import golomb_mark_counter_pkg::*;
#(
    parameter int NUMPOSITIONS = DEF_NUMPOSITIONS,
    parameter int MAXVALUE     = DEF_MAXVALUE,
    parameter int VALW         = DEF_VALW,
    parameter int NUMW         = DEF_NUMW
);
    logic                              ready;
    logic                              globalready;
    logic [VALW-1:0]                   resetvalue;
    logic [VALW-1:0]                   startvalue;
    logic [VALW-1:0]                   limit;
    logic [NUMW-1:0]                   enabled;
    logic [VALW-1:0]                   val;
    logic [NUMW-1:0]                   nextEnabled;
    logic [VALW-1:0]                   nextStartValue;
    logic [1:MAXVALUE]                 distances;
    logic [1:MAXVALUE]                 pdHash;
    logic [(NUMPOSITIONS+1)*VALW-1:0]  marks_in;
    logic                              success;

    modport master (
        input  ready, val, nextEnabled, nextStartValue, pdHash, success,
        output globalready, resetvalue, startvalue, limit, enabled,
               distances, marks_in
    );

    modport slave (
        output ready, val, nextEnabled, nextStartValue, pdHash, success,
        input  globalready, resetvalue, startvalue, limit, enabled,
               distances, marks_in
    );

endinterface

// File: rtl/golomb_diff_hash.sv
// One-hot set of the differences between a value and the marks below
// POSITION; differences outside 1..MAXVALUE are dropped.
module golomb_diff_hash
    import golomb_mark_counter_pkg::*;
#(
    parameter int POSITION     = 1,
    parameter int NUMPOSITIONS = DEF_NUMPOSITIONS,
    parameter int MAXVALUE     = DEF_MAXVALUE,
    parameter int VALW         = DEF_VALW
) (
    input  logic [VALW-1:0]                  cand,
    input  logic [(NUMPOSITIONS+1)*VALW-1:0] marks_in,
    output logic [1:MAXVALUE]                hash
);

    logic [MARKS_MAX_W-1:0] flat_ext;
    assign flat_ext = MARKS_MAX_W'(marks_in);

    // Mark every distance cand - m[i] for the lower marks.
    always_comb begin
        logic [VALW-1:0] m;
        logic [VALW-1:0] diff;
        hash = '0;
        for (int i = 0; i < POSITION; i++) begin
            m    = mark_at(flat_ext, i, NUMPOSITIONS);
            diff = cand - m;
            if (cand > m) begin
                for (int b = 1; b <= MAXVALUE; b++) begin
                    if (diff == VALW'(b)) hash[b] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/golomb_mark_head.sv
// Mark 0 of the ruler: always at position 0, successor starts at 1.
module golomb_mark_head
    import golomb_mark_counter_pkg::*;
#(
    parameter int VALW = DEF_VALW
) (
    output logic [VALW-1:0] val,
    output logic [VALW-1:0] nextStartValue
);

    assign val            = '0;
    assign nextStartValue = VALW'(1);

endmodule

// File: rtl/golomb_mark_counter.sv
// One movable mark of the Golomb-ruler search. When enabled it walks
// candidates upward one per clock until it finds a position whose
// distances to all lower marks are unused (accept) or runs past the
// limit (backtrack). The leaf variant flags a complete ruler on accept.
module golomb_mark_counter
    import golomb_mark_counter_pkg::*;
#(
    parameter int POSITION     = 1,
    parameter int NUMPOSITIONS = DEF_NUMPOSITIONS,
    parameter int MAXVALUE     = DEF_MAXVALUE,
    parameter int VALW         = DEF_VALW,
    parameter int NUMW         = DEF_NUMW,
    parameter bit LEAF         = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    golomb_mark_counter_if.slave  bus
);

    mark_state_e       state_q, state_d;
    logic [VALW-1:0]   val_q, val_d;
    logic [VALW-1:0]   cand_q, cand_d;
    logic [NUMW-1:0]   next_enabled_q, next_enabled_d;
    logic [VALW-1:0]   next_start_q, next_start_d;
    logic              success_q, success_d;

    logic [1:MAXVALUE] cand_hash;
    logic [1:MAXVALUE] val_hash;
    logic              exceed;
    logic              collide;

    golomb_diff_hash #(
        .POSITION     (POSITION),
        .NUMPOSITIONS (NUMPOSITIONS),
        .MAXVALUE     (MAXVALUE),
        .VALW         (VALW)
    ) u_cand_hash (
        .cand     (cand_q),
        .marks_in (bus.marks_in),
        .hash     (cand_hash)
    );

    golomb_diff_hash #(
        .POSITION     (POSITION),
        .NUMPOSITIONS (NUMPOSITIONS),
        .MAXVALUE     (MAXVALUE),
        .VALW         (VALW)
    ) u_val_hash (
        .cand     (val_q),
        .marks_in (bus.marks_in),
        .hash     (val_hash)
    );

    // Exceed wins over collide, so an out-of-range candidate never accepts.
    assign exceed  = (cand_q > bus.limit) || (cand_q > VALW'(MAXVALUE));
    assign collide = |(cand_hash & bus.distances);

    // Next-state: capture on enable in IDLE, one candidate per clock in SEARCH.
    always_comb begin
        state_d        = state_q;
        val_d          = val_q;
        cand_d         = cand_q;
        next_enabled_d = next_enabled_q;
        next_start_d   = next_start_q;
        success_d      = success_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.enabled == NUMW'(POSITION) && bus.globalready) begin
                    cand_d    = (val_q == '0) ? bus.startvalue : val_q + VALW'(1);
                    success_d = 1'b0;
                    state_d   = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (exceed) begin
                    val_d          = '0;
                    next_enabled_d = NUMW'(POSITION - 1);
                    success_d      = 1'b0;
                    state_d        = ST_IDLE;
                end else if (collide) begin
                    cand_d = cand_q + VALW'(1);
                end else begin
                    val_d          = cand_q;
                    next_start_d   = cand_q + VALW'(1);
                    next_enabled_d = LEAF ? NUMW'(POSITION) : NUMW'(POSITION + 1);
                    success_d      = LEAF;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset reloads the mark's preset position.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            val_q          <= bus.resetvalue;
            cand_q         <= '0;
            next_enabled_q <= LEAF ? NUMW'(POSITION) : NUMW'(POSITION + 1);
            next_start_q   <= bus.resetvalue + VALW'(1);
            success_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            val_q          <= val_d;
            cand_q         <= cand_d;
            next_enabled_q <= next_enabled_d;
            next_start_q   <= next_start_d;
            success_q      <= success_d;
        end
    end

    // A searching mark hides its own distances so they do not self-collide.
    assign bus.pdHash         = (LEAF || state_q == ST_SEARCH || val_q == '0) ? '0 : val_hash;
    assign bus.ready          = (state_q == ST_IDLE);
    assign bus.val            = val_q;
    assign bus.nextEnabled    = next_enabled_q;
    assign bus.nextStartValue = LEAF ? '0 : next_start_q;
    assign bus.success        = LEAF ? success_q : 1'b0;

endmodule

// File: tb/tb_golomb_mark_counter.sv
module tb_golomb_mark_counter;
    import golomb_mark_counter_pkg::*;

    localparam int VW = 9;
    localparam int NW = 4;
    localparam int MV = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    golomb_mark_counter_if #(.NUMPOSITIONS(5), .MAXVALUE(MV), .VALW(VW), .NUMW(NW)) c_if ();
    golomb_mark_counter_if #(.NUMPOSITIONS(4), .MAXVALUE(MV), .VALW(VW), .NUMW(NW)) l_if ();
    golomb_mark_counter_if #(.NUMPOSITIONS(5), .MAXVALUE(MV), .VALW(VW), .NUMW(NW)) f_if ();

    golomb_mark_counter #(.POSITION(2), .NUMPOSITIONS(5), .MAXVALUE(MV), .VALW(VW), .NUMW(NW), .LEAF(1'b0))
        u_center (.clock(clk), .reset(rst_n), .bus(c_if.slave));
    golomb_mark_counter #(.POSITION(4), .NUMPOSITIONS(4), .MAXVALUE(MV), .VALW(VW), .NUMW(NW), .LEAF(1'b1))
        u_leaf (.clock(clk), .reset(rst_n), .bus(l_if.slave));
    golomb_mark_counter #(.POSITION(2), .NUMPOSITIONS(5), .MAXVALUE(MV), .VALW(VW), .NUMW(NW), .LEAF(1'b0))
        u_fixed (.clock(clk), .reset(rst_n), .bus(f_if.slave));

    logic [VW-1:0] head_val, head_nsv;
    golomb_mark_head #(.VALW(VW)) u_head (.val(head_val), .nextStartValue(head_nsv));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state for the center mark (POSITION=2).
    int          model_m[0:5];
    logic [1:MV] model_dist;
    int          model_val;
    int          model_nsv;

    function automatic logic [6*VW-1:0] pack_center();
        logic [6*VW-1:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) r[(5-i)*VW +: VW] = VW'(model_m[i]);
        return r;
    endfunction

    function automatic logic [1:MV] model_hash(input int v, input int nm);
        logic [1:MV] r;
        int d;
        r = '0;
        if (v != 0) begin
            for (int i = 0; i < nm; i++) begin
                d = v - model_m[i];
                if (d >= 1 && d <= MV) r[d] = 1'b1;
            end
        end
        return r;
    endfunction

    // Walk candidates from 'first': out of range -> backtrack, else accept
    // the first candidate none of whose distances to m[0..1] is already used.
    task automatic model_search(input int first, input int lim,
                                output int res_val, output int k, output bit ok);
        int  c;
        int  d;
        bit  hit;
        c = first;
        k = 0;
        ok = 0;
        res_val = 0;
        while (1) begin
            k++;
            if (c > lim || c > MV) begin
                ok = 0; res_val = 0;
                return;
            end
            hit = 0;
            for (int i = 0; i < 2; i++) begin
                d = c - model_m[i];
                if (d >= 1 && d <= MV && model_dist[d]) hit = 1;
            end
            if (!hit) begin
                ok = 1; res_val = c;
                return;
            end
            c++;
        end
    endtask

    // Enable one mark for a single capture edge and count cycles with ready low.
    task automatic run_search(input int sel, output int k, output bit timed_out);
        logic rdy;
        @(negedge clk);
        if (sel == 0) c_if.enabled = NW'(2);
        else          l_if.enabled = NW'(4);
        @(posedge clk);
        #1;
        c_if.enabled = '0;
        l_if.enabled = '0;
        k = 0;
        timed_out = 0;
        while (1) begin
            @(negedge clk);
            rdy = (sel == 0) ? c_if.ready : l_if.ready;
            if (rdy) break;
            k++;
            if (k > 300) begin
                timed_out = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_checks++; if (c_if.val !== 9'd0) $display("FAIL rst_c_val: got %0d want 0", c_if.val); else n_pass++;
        n_checks++; if (c_if.ready !== 1'b1) $display("FAIL rst_c_ready: got %b want 1", c_if.ready); else n_pass++;
        n_checks++; if (c_if.nextEnabled !== 4'd3) $display("FAIL rst_c_nexten: got %0d want 3", c_if.nextEnabled); else n_pass++;
        n_checks++; if (c_if.nextStartValue !== 9'd1) $display("FAIL rst_c_nsv: got %0d want 1", c_if.nextStartValue); else n_pass++;
        n_checks++; if (c_if.pdHash !== '0) $display("FAIL rst_c_pdhash: got %h want 0", c_if.pdHash); else n_pass++;
        n_checks++; if (c_if.success !== 1'b0) $display("FAIL rst_c_success: got %b want 0", c_if.success); else n_pass++;
        n_checks++; if (l_if.nextEnabled !== 4'd4) $display("FAIL rst_l_nexten: got %0d want 4", l_if.nextEnabled); else n_pass++;
        n_checks++; if (l_if.nextStartValue !== 9'd0) $display("FAIL rst_l_nsv: got %0d want 0", l_if.nextStartValue); else n_pass++;
        n_checks++; if (l_if.success !== 1'b0) $display("FAIL rst_l_success: got %b want 0", l_if.success); else n_pass++;
        n_checks++; if (f_if.nextStartValue !== 9'd5) $display("FAIL rst_f_nsv: got %0d want 5", f_if.nextStartValue); else n_pass++;
        n_checks++; if (head_val !== 9'd0) $display("FAIL head_val: got %0d want 0", head_val); else n_pass++;
        n_checks++; if (head_nsv !== 9'd1) $display("FAIL head_nsv: got %0d want 1", head_nsv); else n_pass++;
    endtask

    task automatic test_backtrack();
        int k; bit to;
        model_m = '{0, 1, 0, 0, 0, 0};
        c_if.marks_in = pack_center();
        model_dist = '0; model_dist[1] = 1'b1;
        c_if.distances = model_dist;
        c_if.startvalue = 9'd2;
        c_if.limit = 9'd2;
        run_search(0, k, to);
        n_checks++; if (to) $display("FAIL bt_timeout: ready never returned"); else n_pass++;
        n_checks++; if (k != 2) $display("FAIL bt_ready_low: got %0d cycles want 2", k); else n_pass++;
        n_checks++; if (c_if.val !== 9'd0) $display("FAIL bt_val: got %0d want 0", c_if.val); else n_pass++;
        n_checks++; if (c_if.pdHash !== '0) $display("FAIL bt_pdhash: got %h want 0", c_if.pdHash); else n_pass++;
        n_checks++; if (c_if.nextEnabled !== 4'd1) $display("FAIL bt_nexten: got %0d want 1", c_if.nextEnabled); else n_pass++;
        n_checks++; if (c_if.nextStartValue !== 9'd1) $display("FAIL bt_nsv: got %0d want 1", c_if.nextStartValue); else n_pass++;
    endtask

    task automatic test_collision_step();
        int k; bit to;
        logic [1:MV] exp;
        c_if.limit = 9'd20;
        run_search(0, k, to);
        exp = '0; exp[2] = 1'b1; exp[3] = 1'b1;
        n_checks++; if (to) $display("FAIL col_timeout: ready never returned"); else n_pass++;
        n_checks++; if (k != 2) $display("FAIL col_ready_low: got %0d cycles want 2", k); else n_pass++;
        n_checks++; if (c_if.val !== 9'd3) $display("FAIL col_val: got %0d want 3", c_if.val); else n_pass++;
        n_checks++; if (c_if.pdHash !== exp) $display("FAIL col_pdhash: got %h want %h", c_if.pdHash, exp); else n_pass++;
        n_checks++; if (c_if.nextEnabled !== 4'd3) $display("FAIL col_nexten: got %0d want 3", c_if.nextEnabled); else n_pass++;
        n_checks++; if (c_if.nextStartValue !== 9'd4) $display("FAIL col_nsv: got %0d want 4", c_if.nextStartValue); else n_pass++;
    endtask

    task automatic test_resume();
        int k; bit to;
        logic [1:MV] exp;
        run_search(0, k, to);
        exp = '0; exp[3] = 1'b1; exp[4] = 1'b1;
        n_checks++; if (to) $display("FAIL res_timeout: ready never returned"); else n_pass++;
        n_checks++; if (k != 1) $display("FAIL res_ready_low: got %0d cycles want 1", k); else n_pass++;
        n_checks++; if (c_if.val !== 9'd4) $display("FAIL res_val: got %0d want 4", c_if.val); else n_pass++;
        n_checks++; if (c_if.pdHash !== exp) $display("FAIL res_pdhash: got %h want %h", c_if.pdHash, exp); else n_pass++;
        n_checks++; if (c_if.nextStartValue !== 9'd5) $display("FAIL res_nsv: got %0d want 5", c_if.nextStartValue); else n_pass++;
    endtask

    task automatic test_fixed_mark();
        logic [1:MV] exp;
        exp = '0; exp[3] = 1'b1; exp[4] = 1'b1;
        n_checks++; if (f_if.val !== 9'd4) $display("FAIL fix_val: got %0d want 4", f_if.val); else n_pass++;
        n_checks++; if (f_if.pdHash !== exp) $display("FAIL fix_pdhash: got %h want %h", f_if.pdHash, exp); else n_pass++;
        n_checks++; if (f_if.ready !== 1'b1) $display("FAIL fix_ready: got %b want 1", f_if.ready); else n_pass++;
    endtask

    task automatic test_leaf();
        int k; bit to;
        logic [1:MV] d;
        d = '0;
        d[1] = 1'b1; d[3] = 1'b1; d[4] = 1'b1; d[5] = 1'b1; d[8] = 1'b1; d[9] = 1'b1;
        l_if.distances = d;
        l_if.marks_in = {9'd0, 9'd1, 9'd4, 9'd9, 9'd0};
        l_if.startvalue = 9'd10;
        l_if.limit = 9'd11;
        run_search(1, k, to);
        n_checks++; if (to) $display("FAIL leaf_timeout: ready never returned"); else n_pass++;
        n_checks++; if (k != 2) $display("FAIL leaf_ready_low: got %0d cycles want 2", k); else n_pass++;
        n_checks++; if (l_if.val !== 9'd11) $display("FAIL leaf_val: got %0d want 11", l_if.val); else n_pass++;
        n_checks++; if (l_if.success !== 1'b1) $display("FAIL leaf_success: got %b want 1", l_if.success); else n_pass++;
        n_checks++; if (l_if.nextEnabled !== 4'd4) $display("FAIL leaf_nexten: got %0d want 4", l_if.nextEnabled); else n_pass++;
        n_checks++; if (l_if.pdHash !== '0) $display("FAIL leaf_pdhash: got %h want 0", l_if.pdHash); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (l_if.success !== 1'b1) $display("FAIL leaf_success_hold: got %b want 1", l_if.success); else n_pass++;
        run_search(1, k, to);
        n_checks++; if (to) $display("FAIL leafx_timeout: ready never returned"); else n_pass++;
        n_checks++; if (k != 1) $display("FAIL leafx_ready_low: got %0d cycles want 1", k); else n_pass++;
        n_checks++; if (l_if.val !== 9'd0) $display("FAIL leafx_val: got %0d want 0", l_if.val); else n_pass++;
        n_checks++; if (l_if.success !== 1'b0) $display("FAIL leafx_success: got %b want 0", l_if.success); else n_pass++;
        n_checks++; if (l_if.nextEnabled !== 4'd3) $display("FAIL leafx_nexten: got %0d want 3", l_if.nextEnabled); else n_pass++;
    endtask

    task automatic test_random_center();
        int k, exp_k, exp_val, first, lim;
        bit to, ok;
        logic [1:MV] exp_hash;
        model_val = 4;
        model_nsv = 5;
        for (int it = 0; it < 25; it++) begin
            model_m[0] = 0;
            model_m[1] = int'($urandom_range(1, 30));
            for (int i = 2; i < 6; i++) model_m[i] = int'($urandom_range(0, 511));
            for (int b = 1; b <= MV; b++) model_dist[b] = ($urandom_range(0, 4) == 0);
            lim = ($urandom_range(0, 5) == 0) ? 511 : int'($urandom_range(0, 110));
            @(negedge clk);
            c_if.marks_in   = pack_center();
            c_if.distances  = model_dist;
            c_if.startvalue = VW'($urandom_range(1, 60));
            c_if.limit      = VW'(lim);
            first = (model_val == 0) ? int'(c_if.startvalue) : model_val + 1;
            model_search(first, lim, exp_val, exp_k, ok);
            run_search(0, k, to);
            model_val = exp_val;
            if (ok) model_nsv = exp_val + 1;
            exp_hash = model_hash(model_val, 2);
            n_checks++; if (to) $display("FAIL rnd%0d_timeout: ready never returned", it); else n_pass++;
            n_checks++; if (k != exp_k) $display("FAIL rnd%0d_ready_low: got %0d cycles want %0d", it, k, exp_k); else n_pass++;
            n_checks++; if (c_if.val !== VW'(model_val)) $display("FAIL rnd%0d_val: got %0d want %0d", it, c_if.val, model_val); else n_pass++;
            n_checks++; if (c_if.nextEnabled !== (ok ? 4'd3 : 4'd1)) $display("FAIL rnd%0d_nexten: got %0d want %0d", it, c_if.nextEnabled, ok ? 3 : 1); else n_pass++;
            n_checks++; if (c_if.nextStartValue !== VW'(model_nsv)) $display("FAIL rnd%0d_nsv: got %0d want %0d", it, c_if.nextStartValue, model_nsv); else n_pass++;
            n_checks++; if (c_if.pdHash !== exp_hash) $display("FAIL rnd%0d_pdhash: got %h want %h", it, c_if.pdHash, exp_hash); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_search();
        int k; bit to;
        c_if.startvalue = 9'd1;
        c_if.limit = 9'd0;
        run_search(0, k, to);
        n_checks++; if (c_if.val !== 9'd0) $display("FAIL rms_pre_val: got %0d want 0", c_if.val); else n_pass++;
        model_m = '{0, 1, 0, 0, 0, 0};
        c_if.marks_in = pack_center();
        c_if.distances = '1;
        c_if.limit = 9'd511;
        @(negedge clk);
        c_if.enabled = NW'(2);
        @(posedge clk);
        #1;
        c_if.enabled = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (c_if.ready !== 1'b0) $display("FAIL rms_searching: ready got %b want 0", c_if.ready); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (c_if.val !== 9'd0) $display("FAIL rms_val: got %0d want 0", c_if.val); else n_pass++;
        n_checks++; if (c_if.ready !== 1'b1) $display("FAIL rms_ready: got %b want 1", c_if.ready); else n_pass++;
        n_checks++; if (c_if.nextEnabled !== 4'd3) $display("FAIL rms_nexten: got %0d want 3", c_if.nextEnabled); else n_pass++;
        n_checks++; if (f_if.val !== 9'd4) $display("FAIL rms_fix_val: got %0d want 4", f_if.val); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (c_if.ready !== 1'b1) $display("FAIL rms_idle_after: ready got %b want 1", c_if.ready); else n_pass++;
    endtask

    initial begin
        c_if.enabled = '0; c_if.globalready = 1'b1; c_if.resetvalue = '0;
        c_if.startvalue = '0; c_if.limit = '0; c_if.distances = '0; c_if.marks_in = '0;
        l_if.enabled = '0; l_if.globalready = 1'b1; l_if.resetvalue = '0;
        l_if.startvalue = '0; l_if.limit = '0; l_if.distances = '0; l_if.marks_in = '0;
        f_if.enabled = '0; f_if.globalready = 1'b1; f_if.resetvalue = 9'd4;
        f_if.startvalue = '0; f_if.limit = 9'd20; f_if.distances = '0;
        f_if.marks_in = {9'd0, 9'd1, 36'd0};
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        test_reset();
        test_backtrack();
        test_collision_step();
        test_resume();
        test_fixed_mark();
        test_leaf();
        test_random_center();
        test_reset_mid_search();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
